player_sprite_renderer: RTL and testbench
=========================================

Name: player_sprite_renderer

Overview:
- Drives the player sprite ROM. Each cycle it turns the VGA scan position into a sprite-local ROM address {rom_row, rom_col}, takes the ROM's 12-bit colour back one cycle later, and composites it over the background colour.
- Also handles animation-frame sequencing, horizontal mirroring, transparency keying and per-frame position latching.
- Delays syncs so that pixel colour and syncs leave together. Sits between the VGA timing generator and the RGB/sync output pins.

Parameters:
- SPRITE_W, 32, sprite width in pixels.
- SPRITE_H, 48, height of one animation frame in pixels.
- N_FRAMES, 4, number of animation frames, stacked vertically in the ROM.
- ANIM_DIV, 8, video frames per animation step (≥1).
- V_ACTIVE, 480, visible lines; a frame tick fires at (x==0, y==V_ACTIVE).
- TRANSPARENT, 12'hF0F, colour key treated as see-through.

Ports:
- clk, input, 1, pixel clock.
- rst_n, input, 1, asynchronous active-low reset.
- x, input, 10, current pixel column from the timing generator.
- y, input, 10, current pixel row from the timing generator.
- video_on, input, 1, visible-area flag aligned with x/y.
- hsync_in, input, 1, horizontal sync aligned with x/y.
- vsync_in, input, 1, vertical sync aligned with x/y.
- bg_color, input, 12, background layer colour aligned with x/y.
- pos_x, input, 10, player top-left column, from game logic.
- pos_y, input, 10, player top-left row.
- facing_left, input, 1, mirror the sprite horizontally.
- walking, input, 1, animate when 1; hold frame 0 when 0.
- rom_row, output, 10, row address to the sprite ROM.
- rom_col, output, 10, column address to the sprite ROM.
- rom_color, input, 12, ROM data, valid one cycle after the address.
- rgb, output, 12, composited pixel colour.
- hsync, output, 1, delayed hsync_in.
- vsync, output, 1, delayed vsync_in.

Behaviour:
- Reset (async, rst_n=0):
  - rgb=0, rom_row=0, rom_col=0.
  - hsync=1, vsync=1, and all sync delay stages = 1.
  - Latched position/facing = 0, anim_frame=0, anim_div_cnt=0.
  - Reset mid-frame takes effect immediately. After release, output is valid from the third clock, using position 0 until the next frame tick.
- Frame tick: fires in the cycle where x==0 and y==V_ACTIVE.
  - Latches pos_x, pos_y and facing_left into px, py, pf.
  - These latched values are used for the whole next frame. Position changes mid-frame must not tear the sprite.
- Animation state machine, evaluated only on the frame tick:
  - IDLE (walking=0): anim_frame←0, anim_div_cnt←0.
  - WALK (walking=1): if anim_div_cnt==ANIM_DIV-1, then anim_div_cnt←0 and anim_frame←(anim_frame==N_FRAMES-1)?0:anim_frame+1.
  - Otherwise in WALK: anim_div_cnt++.
  - Entering WALK starts from the current counters, which are 0 after IDLE.
- Hit test: in_box = (x ≥ px) && (x < px+SPRITE_W) && (y ≥ py) && (y < py+SPRITE_H).
  - Sums are computed 11 bits wide, so a sprite straddling 1023 clips and never wraps.
- Address, stage 1 (registered at edge E where x/y are sampled):
  - lc = x−px; if pf=1 then lc = SPRITE_W−1−lc.
  - lr = (y−py) + anim_frame*SPRITE_H.
  - If in_box: rom_row←lr, rom_col←lc. Else both ←0.
  - in_box, video_on, bg_color, hsync_in and vsync_in are registered alongside.
- Stage 2 (edge E+1): the ROM registers the address. rom_color is valid after E+1. Side-band signals are delayed one more stage.
- Stage 3 (edge E+2): rgb is chosen in priority order:
  - 0 if video_on delayed is 0;
  - else rom_color if in_box delayed is 1 and rom_color≠TRANSPARENT;
  - else bg_color delayed.
- hsync/vsync pass through three registers. Total latency from x/y to rgb/syncs is 3 edges (E, E+1, E+2), identical for all outputs.
- Frame tick and an in_box pixel in the same cycle cannot coincide, because y==V_ACTIVE is not visible. The new latch is used from the next cycle on.

Test Plan:
- Reset, then sweep x=0..9 at y=0 with video_on=1, bg=12'h123, pos=(0,0), ROM model returning row/col-derived colours → rgb equals the ROM colour for (0, x−3-cycle-aligned); hsync/vsync equal the inputs delayed exactly 3 cycles.
- pos=(100,50), facing_left=1, pixel (100,50) → rom_col=31, rom_row=0. Pixel (131,50) → rom_col=0. Pixel (132,50) → rgb=bg.
- ROM returns 12'hF0F inside the box → rgb=bg_color; video_on=0 inside the box → rgb=0.
- walking=1, ANIM_DIV=8: over 40 frame ticks anim_frame steps 0,1,2,3,0 every 8 ticks, and pixel (px,py) gives rom_row=anim_frame*48. Dropping walking → anim_frame=0 at the next tick.
- pos_x changed mid-frame (y=200) → rom_col mapping is unchanged until the tick at (0,480), then uses the new pos. pos_x=1000 → pixels 1000..1023 are drawn, with no wrap to x=0..7.
- rst_n pulled low for 1 cycle mid-line → rgb=0 and hsync/vsync=1 immediately (asynchronously); anim_frame=0; correct compositing resumes 3 cycles after release.

Source files
------------

// File: rtl/player_sprite_renderer.sv
// Player sprite renderer: maps the scan position to a sprite-ROM address and
// composites the ROM colour over the background. It also steps the animation
// frame, mirrors the sprite and latches the player position once per video frame.
// x/y to rgb/hsync/vsync latency is three clock edges.
module player_sprite_renderer #(
    parameter int          SPRITE_W    = 32,
    parameter int          SPRITE_H    = 48,
    parameter int          N_FRAMES    = 4,
    parameter int          ANIM_DIV    = 8,
    parameter int          V_ACTIVE    = 480,
    parameter logic [11:0] TRANSPARENT = 12'hF0F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [11:0] bg_color,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    input  logic        facing_left,
    input  logic        walking,
    output logic [9:0]  rom_row,
    output logic [9:0]  rom_col,
    input  logic [11:0] rom_color,
    output logic [11:0] rgb,
    output logic        hsync,
    output logic        vsync
);

    localparam int FW = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
    localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    typedef enum logic {ANIM_IDLE, ANIM_WALK} anim_state_e;

    anim_state_e   state_q, state_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [CW-1:0] div_q, div_d;
    logic [9:0]    px_q, py_q;
    logic          pf_q;

    logic          tick;
    logic [10:0]   x_end, y_end;
    logic          in_box;
    logic [9:0]    lc_raw, lc, lr;

    logic [9:0]    rom_row_q, rom_col_q;
    logic          in_box_p0_q, von_p0_q, hs_p0_q, vs_p0_q;
    logic [11:0]   bg_p0_q;
    logic          in_box_p1_q, von_p1_q, hs_p1_q, vs_p1_q;
    logic [11:0]   bg_p1_q;
    logic [11:0]   rgb_q;
    logic          hsync_q, vsync_q;

    // Priority: blanking, then an opaque sprite pixel, then the background.
    function automatic logic [11:0] composite(input logic von, input logic hit,
                                              input logic [11:0] spr, input logic [11:0] bg);
        if (!von)
            return 12'h000;
        else if (hit && (spr != TRANSPARENT))
            return spr;
        else
            return bg;
    endfunction

    // The frame tick sits on an invisible line, so latching here never tears the sprite.
    assign tick = (x == 10'd0) && (y == 10'(V_ACTIVE));

    // 11-bit box edges so a sprite near column/row 1023 clips instead of wrapping.
    assign x_end  = {1'b0, px_q} + 11'(SPRITE_W);
    assign y_end  = {1'b0, py_q} + 11'(SPRITE_H);
    assign in_box = (x >= px_q) && ({1'b0, x} < x_end) && (y >= py_q) && ({1'b0, y} < y_end);
    assign lc_raw = x - px_q;
    assign lc     = pf_q ? (10'(SPRITE_W - 1) - lc_raw) : lc_raw;
    assign lr     = (y - py_q) + 10'(32'(frame_q) * SPRITE_H);

    // Per-frame position/facing latch and animation registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_q    <= '0;
            py_q    <= '0;
            pf_q    <= 1'b0;
            state_q <= ANIM_IDLE;
            frame_q <= '0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            div_q   <= div_d;
            if (tick) begin
                px_q <= pos_x;
                py_q <= pos_y;
                pf_q <= facing_left;
            end
        end
    end

    // Animation next state: only the frame tick advances or clears the counters.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        div_d   = div_q;
        if (tick) begin
            state_d = walking ? ANIM_WALK : ANIM_IDLE;
            case (state_d)
                ANIM_IDLE: begin
                    frame_d = '0;
                    div_d   = '0;
                end
                ANIM_WALK: begin
                    if (div_q == CW'(ANIM_DIV - 1)) begin
                        div_d   = '0;
                        frame_d = (frame_q == FW'(N_FRAMES - 1)) ? '0 : frame_q + 1'b1;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage 1 control: ROM address and side-band flags sampled with x/y.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_row_q   <= '0;
            rom_col_q   <= '0;
            in_box_p0_q <= 1'b0;
            von_p0_q    <= 1'b0;
            hs_p0_q     <= 1'b1;
            vs_p0_q     <= 1'b1;
        end else begin
            rom_row_q   <= in_box ? lr : 10'd0;
            rom_col_q   <= in_box ? lc : 10'd0;
            in_box_p0_q <= in_box;
            von_p0_q    <= video_on;
            hs_p0_q     <= hsync_in;
            vs_p0_q     <= vsync_in;
        end
    end

    // Background colour pipeline; blanking via von covers its unreset start-up.
    always_ff @(posedge clk) begin
        bg_p0_q <= bg_color;
        bg_p1_q <= bg_p0_q;
    end

    // Stage 2: side-band waits while the ROM registers the address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_box_p1_q <= 1'b0;
            von_p1_q    <= 1'b0;
            hs_p1_q     <= 1'b1;
            vs_p1_q     <= 1'b1;
        end else begin
            in_box_p1_q <= in_box_p0_q;
            von_p1_q    <= von_p0_q;
            hs_p1_q     <= hs_p0_q;
            vs_p1_q     <= vs_p0_q;
        end
    end

    // Stage 3: composite with the now-valid ROM colour; syncs leave alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q   <= 12'h000;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            rgb_q   <= composite(von_p1_q, in_box_p1_q, rom_color, bg_p1_q);
            hsync_q <= hs_p1_q;
            vsync_q <= vs_p1_q;
        end
    end

    assign rom_row = rom_row_q;
    assign rom_col = rom_col_q;
    assign rgb     = rgb_q;
    assign hsync   = hsync_q;
    assign vsync   = vsync_q;

endmodule

// File: tb/tb_player_sprite_renderer.sv
// Scoreboard bench for player_sprite_renderer with a behavioural sprite ROM.
module tb_player_sprite_renderer;

    localparam int SW = 32;
    localparam int SH = 48;
    localparam int NF = 4;
    localparam int AD = 8;
    localparam int VA = 480;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  x = '0, y = '0;
    logic        video_on = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
    logic [11:0] bg_color = '0;
    logic [9:0]  pos_x = '0, pos_y = '0;
    logic        facing_left = 1'b0, walking = 1'b0;
    logic [9:0]  rom_row, rom_col;
    logic [11:0] rom_color = '0;
    logic [11:0] rgb;
    logic        hsync, vsync;

    player_sprite_renderer #(
        .SPRITE_W(SW), .SPRITE_H(SH), .N_FRAMES(NF), .ANIM_DIV(AD),
        .V_ACTIVE(VA), .TRANSPARENT(12'hF0F)
    ) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .video_on(video_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .bg_color(bg_color),
        .pos_x(pos_x), .pos_y(pos_y), .facing_left(facing_left), .walking(walking),
        .rom_row(rom_row), .rom_col(rom_col), .rom_color(rom_color),
        .rgb(rgb), .hsync(hsync), .vsync(vsync)
    );

    always #5 clk = ~clk;

    // Sprite ROM contents: column 7 is keyed transparent, others a hash of row/col.
    function automatic logic [11:0] rom_fn(input int r, input int c);
        int v;
        if (c == 7) return 12'hF0F;
        v = (r * 53 + c * 29 + 7) % 4096;
        if (v == 'hF0F) v = 0;
        return 12'(v);
    endfunction

    // Synchronous ROM: data one cycle after the address.
    always @(posedge clk) rom_color <= rom_fn(int'(rom_row), int'(rom_col));

    typedef struct {
        int          e;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic [9:0]  row;
        logic [9:0]  col;
    } exp_t;

    exp_t aq[$];
    exp_t pq[$];
    exp_t ma, mp;
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    // Reference state: latched position/facing and consecutive walking ticks.
    int mpx = 0, mpy = 0, mpf = 0, wc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: addresses appear after edge E, pixels and syncs after E+2.
    always @(negedge clk) begin
        if (rst_n) begin
            if (aq.size() > 0 && aq[0].e <= cyc) begin
                ma = aq.pop_front();
                check("addr_slot", cyc, ma.e);
                check("rom_row", rom_row, ma.row);
                check("rom_col", rom_col, ma.col);
            end
            if (pq.size() > 0 && pq[0].e + 2 <= cyc) begin
                mp = pq.pop_front();
                check("pix_slot", cyc, mp.e + 2);
                check("rgb", rgb, mp.rgb);
                check("hsync", hsync, mp.hs);
                check("vsync", vsync, mp.vs);
            end
        end
    end

    // Drive one pixel, push its expected response, advance one clock.
    task automatic pix(input int xx, input int yy, input logic von, input logic [11:0] bg,
                       input logic hs, input logic vs);
        exp_t it;
        int lr, lc, frame;
        bit inb;
        logic [11:0] c;
        x = 10'(xx); y = 10'(yy); video_on = von; bg_color = bg;
        hsync_in = hs; vsync_in = vs;
        frame = (wc / AD) % NF;
        inb = (xx >= mpx) && (xx < mpx + SW) && (yy >= mpy) && (yy < mpy + SH);
        lc = (mpf != 0) ? (SW - 1 - (xx - mpx)) : (xx - mpx);
        lr = (yy - mpy) + frame * SH;
        c = rom_fn(lr, lc);
        it.e   = cyc + 1;
        it.row = inb ? 10'(lr) : 10'd0;
        it.col = inb ? 10'(lc) : 10'd0;
        it.rgb = !von ? 12'h000 : ((inb && c != 12'hF0F) ? c : bg);
        it.hs  = hs;
        it.vs  = vs;
        aq.push_back(it);
        pq.push_back(it);
        if (xx == 0 && yy == VA) begin
            mpx = int'(pos_x); mpy = int'(pos_y); mpf = int'(facing_left);
            wc  = walking ? wc + 1 : 0;
        end
        @(posedge clk); #1;
    endtask

    task automatic rpix(input int xx, input int yy, input logic von);
        pix(xx, yy, von, 12'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic tick(input int nx, input int ny, input logic nf, input logic w);
        pos_x = 10'(nx); pos_y = 10'(ny); facing_left = nf; walking = w;
        rpix(0, VA, 1'b0);
    endtask

    task automatic reset_outputs_check(input string tag);
        check({tag, "_rgb"}, rgb, 12'h000);
        check({tag, "_hsync"}, hsync, 1'b1);
        check({tag, "_vsync"}, vsync, 1'b1);
        check({tag, "_rom_row"}, rom_row, 10'd0);
        check({tag, "_rom_col"}, rom_col, 10'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int xx, yy, nx, ny;
        // Power-on reset.
        repeat (2) @(posedge clk);
        #1;
        reset_outputs_check("por");
        rst_n = 1'b1;

        // Sweep the top-left corner with position still 0.
        for (int i = 0; i < 10; i++) rpix(i, 0, 1'b1);
        for (int i = 0; i < 10; i++) pix(i, 0, 1'b1, 12'h123, 1'($urandom), 1'($urandom));

        // Mirrored sprite at (100,50): edges, past the edge, keyed column, blanking.
        tick(100, 50, 1'b1, 1'b0);
        rpix(100, 50, 1'b1);
        rpix(131, 50, 1'b1);
        rpix(132, 50, 1'b1);
        rpix(124, 60, 1'b1);
        rpix(110, 60, 1'b0);
        rpix(99, 50, 1'b1);
        rpix(100, 98, 1'b1);

        // Walking animation over 40 ticks.
        for (int i = 0; i < 40; i++) begin
            tick(100, 50, 1'b0, 1'b1);
            rpix(100, 50, 1'b1);
            rpix(100 + $urandom_range(0, 31), 50 + $urandom_range(0, 47), 1'b1);
        end

        // Asynchronous reset mid-line while showing sprite pixels with syncs low.
        for (int i = 0; i < 3; i++) pix(100 + i, 51, 1'b1, 12'h0AA, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        reset_outputs_check("midrst");
        aq.delete(); pq.delete();
        mpx = 0; mpy = 0; mpf = 0; wc = 0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        rpix(0, 0, 1'b1);
        rpix(5, 5, 1'b1);
        rpix(100, 50, 1'b1);

        // Walk again, then drop walking.
        for (int i = 0; i < 10; i++) begin
            tick(40, 30, 1'b0, 1'b1);
            rpix(40, 30, 1'b1);
        end
        tick(40, 30, 1'b0, 1'b0);
        rpix(40, 30, 1'b1);
        rpix(50, 70, 1'b1);

        // Position change mid-frame is ignored until the next tick.
        tick(200, 180, 1'b0, 1'b0);
        rpix(210, 200, 1'b1);
        pos_x = 10'd300;
        rpix(210, 200, 1'b1);
        rpix(310, 200, 1'b1);
        tick(300, 180, 1'b0, 1'b0);
        rpix(310, 200, 1'b1);
        rpix(210, 200, 1'b1);

        // Sprite straddling column 1023 clips without wrapping.
        tick(1000, 180, 1'b0, 1'b0);
        for (int i = 1000; i < 1024; i++) rpix(i, 200, 1'b1);
        for (int i = 0; i < 8; i++) rpix(i, 200, 1'b1);

        // Randomized frames.
        for (int f = 0; f < 30; f++) begin
            nx = $urandom_range(0, 1023);
            ny = $urandom_range(0, 430);
            tick(nx, ny, 1'($urandom), ($urandom_range(0, 3) != 0));
            for (int k = 0; k < 15; k++) begin
                if (k % 2 == 0) begin
                    xx = nx + $urandom_range(0, 35) - 2;
                    yy = ny + $urandom_range(0, 51) - 2;
                    if (xx < 0) xx = 0;
                    if (xx > 1023) xx = 1023;
                    if (yy < 0) yy = 0;
                end else begin
                    xx = $urandom_range(0, 1023);
                    yy = $urandom_range(0, 479);
                end
                rpix(xx, yy, ($urandom_range(0, 7) != 0));
            end
        end

        // Let the pipeline drain, then confirm every expectation was consumed.
        video_on = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("drain_addr", aq.size(), 0);
        check("drain_pix", pq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
